// File: rtl/rand_range_sampler.sv
// Seeds an external XNOR LFSR from a free-running entropy count, then rejection-samples its
// output into a uniform index in [0, RANGE-1] delivered over valid/ready.
// Optional feature: define NO_REPEAT_EN to forbid consecutive repeated indices.

module rand_range_sampler #(
    parameter int unsigned NUM_BITS  = 8,
    parameter int unsigned RANGE     = 9,
    parameter int unsigned OUT_W     = 4,
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                seed_btn_i,
    output logic                lfsr_en_o,
    output logic                lfsr_seed_o,
    output logic [NUM_BITS-1:0] lfsr_seed_data_o,
    input  logic [NUM_BITS-1:0] lfsr_data_i,
    output logic [OUT_W-1:0]    value_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                seeded_o
);

    localparam int unsigned TriesW = $clog2(MAX_TRIES + 1);
    localparam logic [OUT_W:0] RangeW = (OUT_W + 1)'(RANGE);
    localparam logic [TriesW-1:0] LastTry = TriesW'(MAX_TRIES - 1);
    localparam logic [TriesW-1:0] TriesSat = TriesW'(MAX_TRIES);

    typedef enum logic [1:0] {
        StUnseeded,
        StSeed,
        StDraw,
        StHold
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_BITS-1:0] entropy_q, entropy_d;
    logic [NUM_BITS-1:0] seed_q, seed_d;
    logic [OUT_W-1:0]    value_q, value_d;
    logic                valid_q, valid_d;
    logic                seeded_q, seeded_d;
    logic [TriesW-1:0]   tries_q, tries_d;

    logic [OUT_W-1:0]    cand;
    logic                cand_in_range;
    logic                cand_repeat;
    logic                accept;
    logic [OUT_W-1:0]    fallback;

    assign cand          = lfsr_data_i[OUT_W-1:0];
    // Widened compare so RANGE == 2**OUT_W stays representable.
    assign cand_in_range = ({1'b0, cand} < RangeW);
    assign accept        = cand_in_range & ~cand_repeat;

    if (NUM_BITS > OUT_W) begin : g_unused_hi
        logic unused_lfsr_hi;
        assign unused_lfsr_hi = ^lfsr_data_i[NUM_BITS-1:OUT_W];
    end

`ifdef NO_REPEAT_EN
    logic [OUT_W-1:0] last_q, last_d;
    logic             have_last_q, have_last_d;
    logic [OUT_W:0]   last_inc;

    assign last_inc    = {1'b0, last_q} + 1'b1;
    assign cand_repeat = have_last_q && (cand == last_q);
    assign fallback    = !have_last_q        ? '0 :
                         (last_inc == RangeW) ? '0 : last_inc[OUT_W-1:0];

    always_comb begin
        last_d      = last_q;
        have_last_d = have_last_q;
        if (state_q == StHold && ready_i && valid_q) begin
            last_d      = value_q;
            have_last_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q      <= '0;
            have_last_q <= 1'b0;
        end else begin
            last_q      <= last_d;
            have_last_q <= have_last_d;
        end
    end
`else
    assign cand_repeat = 1'b0;
    assign fallback    = '0;
`endif

    assign entropy_d = entropy_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        seed_d   = seed_q;
        value_d  = value_q;
        valid_d  = valid_q;
        seeded_d = seeded_q;
        tries_d  = tries_q;

        unique case (state_q)
            StUnseeded: begin
                if (seed_btn_i) begin
                    // All-ones is the XNOR lockup state and must never be loaded.
                    seed_d  = (&entropy_q) ? '0 : entropy_q;
                    state_d = StSeed;
                end
            end
            StSeed: begin
                seeded_d = 1'b1;
                tries_d  = '0;
                state_d  = StDraw;
            end
            StDraw: begin
                if (accept) begin
                    value_d = cand;
                    valid_d = 1'b1;
                    state_d = StHold;
                end else if (tries_q >= LastTry) begin
                    value_d = fallback;
                    valid_d = 1'b1;
                    tries_d = TriesSat;
                    state_d = StHold;
                end else begin
                    tries_d = tries_q + 1'b1;
                end
            end
            StHold: begin
                if (ready_i && valid_q) begin
                    valid_d = 1'b0;
                    tries_d = '0;
                    state_d = StDraw;
                end
            end
            default: state_d = StUnseeded;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StUnseeded;
            entropy_q <= '0;
            seed_q    <= '0;
            value_q   <= '0;
            valid_q   <= 1'b0;
            seeded_q  <= 1'b0;
            tries_q   <= '0;
        end else begin
            state_q   <= state_d;
            entropy_q <= entropy_d;
            seed_q    <= seed_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            seeded_q  <= seeded_d;
            tries_q   <= tries_d;
        end
    end

    assign lfsr_en_o        = (state_q == StSeed) || (state_q == StDraw);
    assign lfsr_seed_o      = (state_q == StSeed);
    assign lfsr_seed_data_o = (state_q == StSeed) ? seed_q : '0;
    assign value_o          = value_q;
    assign valid_o          = valid_q;
    assign seeded_o         = seeded_q;

`ifndef SYNTHESIS
    a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_o && !ready_i) |=> (valid_o && $stable(value_o)));
    a_value_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        valid_o |-> ({1'b0, value_o} < RangeW));
`endif

endmodule
